// File: rtl/column_coef_pkg.sv
// Shared types and constants for the column coefficient sequencer:
// FSM state encoding, packed {sigma, delta} table word, unity-gain helper.
package column_coef_pkg;

   localparam int COEF_SIGMA_BITS = 8;
   localparam int COEF_DELTA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_OVERRUN = 2'd2
   } col_state_e;

   typedef struct packed {
      logic [COEF_SIGMA_BITS-1:0] sigma;
      logic [COEF_DELTA_BITS-1:0] delta;
   } coef_t;

   function automatic logic [31:0] unity_gain(input int frac_bits);
      return 32'd1 << frac_bits;
   endfunction

endpackage

// File: rtl/column_coef_ram.sv
// Simple dual-port coefficient table: one write port, one registered read port.
// No reset on the storage or the read register.
module column_coef_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12,
   parameter int W     = 16
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // A read colliding with a write returns the old word.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/column_coef_sequencer.sv
// Per-column sigma/delta streamer aligned to the pixel with one cycle of latency.
// COLUMN_COEF_DOUBLE_BUFFER_EN selects a shadow/active bank pair swapped at line start.
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  ST_IDLE    | after reset or after the last column of a line
//  ST_ACTIVE  | inside a line, col_q is the next column
//  ST_OVERRUN | pixels beyond column COLS-1, waiting for sol_i
module column_coef_sequencer
   import column_coef_pkg::*;
#(
   parameter int COLS            = 4096,
   parameter int COL_BITS        = 12,
   parameter int DATA_BITS       = 8,
   parameter int SIGMA_BITS      = COEF_SIGMA_BITS,
   parameter int SIGMA_FRAC_BITS = 7,
   parameter int DELTA_BITS      = COEF_DELTA_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [COL_BITS-1:0]   cfg_addr,
   input  logic [SIGMA_BITS-1:0] cfg_sigma,
   input  logic [DELTA_BITS-1:0] cfg_delta,
   input  logic                  cfg_commit,
   input  logic [DATA_BITS-1:0]  data_i,
   input  logic                  valid_i,
   input  logic                  sol_i,
   output logic [DATA_BITS-1:0]  data_o,
   output logic [SIGMA_BITS-1:0] sigma_o,
   output logic [DELTA_BITS-1:0] delta_o,
   output logic                  valid_o,
   output logic                  overrun_o,
   output logic                  table_ok_o
);

   localparam int CIDX = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [COL_BITS-1:0]   LAST_COL = COL_BITS'(COLS - 1);
   localparam logic [COL_BITS:0]     COLS_W   = (COL_BITS + 1)'(COLS);
   localparam logic [SIGMA_BITS-1:0] UNITY    = SIGMA_BITS'(unity_gain(SIGMA_FRAC_BITS));

   col_state_e state_q;
   logic [COL_BITS-1:0]  col_q;
   logic [DATA_BITS-1:0] data_q;
   logic valid_q, overrun_q, table_ok_q, line_ok_q, use_tab_q;

   logic            sol_pix, wr_ok, line_ok_now, tab_hit;
   logic [CIDX-1:0] rd_idx;
   coef_t           wr_coef, rd_coef;

   assign sol_pix = valid_i & sol_i;
   assign wr_ok   = cfg_we & ({1'b0, cfg_addr} < COLS_W);
   assign rd_idx  = sol_pix ? '0 : col_q[CIDX-1:0];
   assign wr_coef = '{sigma: cfg_sigma, delta: cfg_delta};

   // Table usage is decided once per line so a commit never takes effect mid-line.
   assign tab_hit = sol_pix ? line_ok_now : ((state_q == ST_ACTIVE) & line_ok_q);

`ifdef COLUMN_COEF_DOUBLE_BUFFER_EN
   logic  bank_q, pend_q, bank_ok_q, rd_bank_q, swap, rd_bank;
   coef_t rd_coef0, rd_coef1;

   assign swap        = pend_q & (sol_pix | ((state_q == ST_IDLE) & ~valid_i));
   assign rd_bank     = (sol_pix & pend_q) ? ~bank_q : bank_q;
   assign line_ok_now = pend_q | bank_ok_q;
   assign rd_coef     = rd_bank_q ? rd_coef1 : rd_coef0;

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q    <= 1'b0;
         pend_q    <= 1'b0;
         bank_ok_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else begin
         if (swap) begin
            bank_q    <= ~bank_q;
            bank_ok_q <= 1'b1;
         end
         pend_q <= swap ? 1'b0 : (pend_q | cfg_commit);
         if (valid_i) rd_bank_q <= rd_bank;
      end
   end

   column_coef_ram #(.DEPTH(COLS), .AW(CIDX), .W($bits(coef_t))) u_ram0 (
      .clk_i(clk), .we_i(wr_ok & bank_q), .waddr_i(cfg_addr[CIDX-1:0]), .wdata_i(wr_coef),
      .re_i(valid_i), .raddr_i(rd_idx), .rdata_o(rd_coef0)
   );
   column_coef_ram #(.DEPTH(COLS), .AW(CIDX), .W($bits(coef_t))) u_ram1 (
      .clk_i(clk), .we_i(wr_ok & ~bank_q), .waddr_i(cfg_addr[CIDX-1:0]), .wdata_i(wr_coef),
      .re_i(valid_i), .raddr_i(rd_idx), .rdata_o(rd_coef1)
   );
`else
   assign line_ok_now = table_ok_q;

   column_coef_ram #(.DEPTH(COLS), .AW(CIDX), .W($bits(coef_t))) u_ram (
      .clk_i(clk), .we_i(wr_ok), .waddr_i(cfg_addr[CIDX-1:0]), .wdata_i(wr_coef),
      .re_i(valid_i), .raddr_i(rd_idx), .rdata_o(rd_coef)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         table_ok_q <= 1'b0;
         line_ok_q  <= 1'b0;
         use_tab_q  <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (cfg_commit) table_ok_q <= 1'b1;
         if (valid_i) begin
            data_q    <= data_i;
            use_tab_q <= tab_hit;
         end
         if (sol_pix) begin
            line_ok_q <= line_ok_now;
            state_q   <= (COLS == 1) ? ST_IDLE : ST_ACTIVE;
            col_q     <= (COLS == 1) ? '0 : COL_BITS'(1);
         end else if (valid_i) begin
            case (state_q)
               ST_ACTIVE: begin
                  if (col_q == LAST_COL) begin
                     state_q <= ST_IDLE;
                     col_q   <= '0;
                  end else begin
                     col_q <= col_q + COL_BITS'(1);
                  end
               end
               ST_IDLE: begin
                  state_q   <= ST_OVERRUN;
                  overrun_q <= 1'b1;
               end
               ST_OVERRUN: state_q <= ST_OVERRUN;
               default:    state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign overrun_o  = overrun_q;
   assign table_ok_o = table_ok_q;
   assign sigma_o    = use_tab_q ? rd_coef.sigma : UNITY;
   assign delta_o    = use_tab_q ? rd_coef.delta : '0;

endmodule

// File: tb/tb_column_coef_sequencer.sv
// Directed bench for column_coef_sequencer with COLS=4; expectations follow
// COLUMN_COEF_DOUBLE_BUFFER_EN when the mid-line rewrite is exercised.
module tb_column_coef_sequencer;

   logic        clk = 1'b0;
   logic        rst, cfg_we, cfg_commit, valid_i, sol_i;
   logic [11:0] cfg_addr;
   logic [7:0]  cfg_sigma, cfg_delta, data_i;
   logic [7:0]  data_o, sigma_o, delta_o;
   logic        valid_o, overrun_o, table_ok_o;

   int n_tot = 0;
   int n_bad = 0;

   logic [7:0] sig_tab [4];
   logic [7:0] del_tab [4];

   column_coef_sequencer #(.COLS(4)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sigma(cfg_sigma), .cfg_delta(cfg_delta),
      .cfg_commit(cfg_commit),
      .data_i(data_i), .valid_i(valid_i), .sol_i(sol_i),
      .data_o(data_o), .sigma_o(sigma_o), .delta_o(delta_o), .valid_o(valid_o),
      .overrun_o(overrun_o), .table_ok_o(table_ok_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [7:0] d, input logic s, input logic [7:0] es, input logic [7:0] ed,
                      input string tag);
      valid_i = 1'b1;
      sol_i   = s;
      data_i  = d;
      tick();
      valid_i = 1'b0;
      sol_i   = 1'b0;
      chk({tag, ".valid"}, valid_o, 1);
      chk({tag, ".data"},  data_o,  d);
      chk({tag, ".sigma"}, sigma_o, es);
      chk({tag, ".delta"}, delta_o, ed);
   endtask

   task automatic wr(input logic [11:0] a, input logic [7:0] s, input logic [7:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_sigma = s;
      cfg_delta = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".data"},     data_o,     0);
      chk({tag, ".sigma"},    sigma_o,    128);
      chk({tag, ".delta"},    delta_o,    0);
      chk({tag, ".valid"},    valid_o,    0);
      chk({tag, ".overrun"},  overrun_o,  0);
      chk({tag, ".table_ok"}, table_ok_o, 0);
   endtask

   task automatic table_line(input logic [7:0] base, input string tag);
      for (int i = 0; i < 4; i++)
         pix(base + 8'(i), (i == 0), sig_tab[i], del_tab[i], $sformatf("%s%0d", tag, i));
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; valid_i = 1'b0; sol_i = 1'b0;
      cfg_addr = '0; cfg_sigma = '0; cfg_delta = '0; data_i = '0;
      sig_tab = '{8'd128, 8'd64, 8'd255, 8'd0};
      del_tab = '{8'h00, 8'hFB, 8'h0A, 8'h80};
      tick(); tick();
      rst = 1'b0;
      chk_reset("rst");

      // line without a committed table: unity everywhere
      for (int i = 0; i < 4; i++)
         pix(8'h20 + 8'(i), (i == 0), 8'd128, 8'h00, $sformatf("nocommit%0d", i));
      tick();
      chk("nocommit.lag_valid", valid_o, 0);
      chk("nocommit.hold_data", data_o, 8'h23);

      // load table; out-of-range address must be dropped (would alias column 0)
      for (int i = 0; i < 4; i++) wr(12'(i), sig_tab[i], del_tab[i]);
      wr(12'd4, 8'd99, 8'd99);
      commit();
      tick(); tick();
      chk("load.table_ok", table_ok_o, 1);
      table_line(8'h30, "tab");
      chk("tab.table_ok", table_ok_o, 1);
      chk("tab.no_overrun", overrun_o, 0);

      // six pixels on one sol: last two overrun with unity
      table_line(8'h40, "ovr");
      pix(8'h44, 1'b0, 8'd128, 8'h00, "ovr4");
      chk("ovr4.flag", overrun_o, 1);
      pix(8'h45, 1'b0, 8'd128, 8'h00, "ovr5");
      tick();
      chk("ovr.sticky", overrun_o, 1);
      table_line(8'h50, "after_ovr");
      chk("after_ovr.sticky", overrun_o, 1);

      // valid gaps inside a line: column and outputs hold
      pix(8'h60, 1'b1, sig_tab[0], del_tab[0], "gap0");
      pix(8'h61, 1'b0, sig_tab[1], del_tab[1], "gap1");
      tick(); tick();
      chk("gap.valid", valid_o, 0);
      chk("gap.hold_sigma", sigma_o, sig_tab[1]);
      chk("gap.hold_delta", delta_o, del_tab[1]);
      chk("gap.hold_data", data_o, 8'h61);
      pix(8'h62, 1'b0, sig_tab[2], del_tab[2], "gap2");
      tick();
      pix(8'h63, 1'b0, sig_tab[3], del_tab[3], "gap3");
      tick();

      // rewrite column 1 to 200 and commit mid-line
      pix(8'h70, 1'b1, sig_tab[0], del_tab[0], "mid0");
      sig_tab[1] = 8'd200;
      for (int i = 0; i < 4; i++) wr(12'(i), sig_tab[i], del_tab[i]);
      commit();
`ifdef COLUMN_COEF_DOUBLE_BUFFER_EN
      pix(8'h71, 1'b0, 8'd64, del_tab[1], "mid1");
`else
      pix(8'h71, 1'b0, 8'd200, del_tab[1], "mid1");
`endif
      pix(8'h72, 1'b0, sig_tab[2], del_tab[2], "mid2");
      pix(8'h73, 1'b0, sig_tab[3], del_tab[3], "mid3");
      tick();
      table_line(8'h80, "next");

      // reset mid-line
      pix(8'h90, 1'b1, sig_tab[0], del_tab[0], "prerst0");
      pix(8'h91, 1'b0, sig_tab[1], del_tab[1], "prerst1");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("midrst");
      pix(8'hA0, 1'b0, 8'd128, 8'h00, "postrst_ovr");
      chk("postrst.overrun", overrun_o, 1);
      chk("postrst.table_ok", table_ok_o, 0);
      for (int i = 0; i < 4; i++)
         pix(8'hB0 + 8'(i), (i == 0), 8'd128, 8'h00, $sformatf("postrst%0d", i));
      tick();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
